hist_eq_cfg_ctrl: RTL
=====================

HIST_EQ_CFG_CTRL -- requirements
Module: hist_eq_cfg_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel and contrast-threshold width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2**22, cycles without start-of-frame before a stall is declared.
REQ-003 SHALL have port i_sys_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_sys_aresetn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port cfg_wr_valid  input  1  shadow-register write request.
REQ-006 SHALL have port cfg_wr_ready  output  1  write/commit acceptance.
REQ-007 SHALL have port cfg_wr_addr  input  2  0 = contrast threshold, 1 = upper bound, 2 = lower bound, 3 = thresholding enable (bit 0).
REQ-008 SHALL have port cfg_wr_data  input  10  write data; contrast threshold uses [DATA_WIDTH-1:0].
REQ-009 SHALL have port cfg_commit  input  1  request to apply the shadow set at the next frame start.
REQ-010 SHALL have ports mon_tvalid, mon_tuser  input  1 each  taps of the datapath's input AXI-Stream.
REQ-011 SHALL have port contrast_threshold_param  output  DATA_WIDTH  active contrast threshold.
REQ-012 SHALL have ports upper_bound_param, lower_bound_param  output  10 each  active bounds (x/1024).
REQ-013 SHALL have port thresholding_en  output  1  active mask enable.
REQ-014 SHALL have ports cfg_pending, cfg_applied, cfg_err, cfg_forced, stream_stall  output  1 each  status.
REQ-015 SHALL have port frame_cnt  output  16  count of frame starts seen.

Function
REQ-016 SOF SHALL be mon_tvalid & mon_tuser in the same cycle.
REQ-017 FSM states SHALL be IDLE, ARMED and APPLY.
REQ-018 In IDLE, cfg_wr_ready SHALL be 1; a write (cfg_wr_valid & cfg_wr_ready) SHALL update the addressed shadow register at that edge.
REQ-019 In ARMED and APPLY, cfg_wr_ready SHALL be 0; writes and commits SHALL be ignored.
REQ-020 A commit in IDLE SHALL validate the shadow set: lower_bound < upper_bound and upper_bound != 0.
REQ-021 A write and a commit in the same cycle SHALL validate the post-write shadow value.
REQ-022 Invalid commit: cfg_err SHALL be set (sticky) and the FSM SHALL stay in IDLE.
REQ-023 Valid commit: cfg_err SHALL clear and the FSM SHALL enter ARMED with cfg_pending = 1.
REQ-024 In ARMED, on SOF the active registers SHALL load from shadow at that same edge, and the FSM SHALL go to APPLY.
REQ-025 In ARMED, if the stall counter reaches TIMEOUT_CYCLES, active SHALL load from shadow, cfg_forced SHALL be set (sticky until the next valid commit), and the FSM SHALL go to APPLY.
REQ-026 APPLY SHALL last exactly one cycle with cfg_applied = 1, then return to IDLE; cfg_pending SHALL be 0 in IDLE and APPLY.
REQ-027 A SOF arriving in IDLE or APPLY SHALL NOT change the active registers.
REQ-028 frame_cnt SHALL increment on every SOF in any state and wrap 0xFFFF -> 0.
REQ-029 The stall counter SHALL clear on SOF, otherwise increment and saturate at TIMEOUT_CYCLES; stream_stall SHALL be 1 while it equals TIMEOUT_CYCLES.
REQ-030 A SOF in the cycle the counter would reach TIMEOUT_CYCLES SHALL take priority: counter cleared, normal apply, no force.
REQ-031 Active outputs SHALL be registered and change only in the ARMED->APPLY transition edge.

Reset
REQ-032 On reset, shadow and active registers SHALL be: contrast 128, upper 717, lower 205, thresholding_en 1.
REQ-033 On reset, FSM SHALL be IDLE, frame_cnt and stall counter SHALL be 0, and every status output SHALL be 0 with cfg_wr_ready = 1 from the first cycle after reset release.
REQ-034 Reset while ARMED SHALL discard the pending set; active values SHALL revert to the defaults.

Structure
REQ-035 The package hist_eq_pkg SHALL hold the state enum, address codes, default parameter values and PIPELINE_LENGTH = 12.
REQ-036 The stall watchdog SHALL be one sub-module, hist_eq_stall_wdt (counter, saturate, clear on SOF); everything else is in the top.

Verification
REQ-037 Scenario: write upper = 800, lower = 100, commit, SOF 50 cycles later -> cfg_pending high for 50 cycles; upper_bound_param = 800 the cycle after SOF; cfg_applied pulses once.
REQ-038 Scenario: write lower = 600, upper = 500, commit -> cfg_err = 1, stays IDLE, active remains 717/205.
REQ-039 Scenario: TIMEOUT_CYCLES = 100, commit, no SOF -> apply after 100 cycles; cfg_forced = 1; stream_stall = 1.
REQ-040 Scenario: write to addr 0 while ARMED -> ignored (cfg_wr_ready = 0); the value applied equals the pre-commit shadow.
REQ-041 Scenario: 65537 SOFs -> frame_cnt = 1; SOFs in IDLE leave active unchanged.
REQ-042 Scenario: reset asserted mid-ARMED -> IDLE, defaults restored, cfg_pending = 0.

Source files
------------

// File: rtl/hist_eq_pkg.sv
// Shared types and constants for the histogram-equalisation configuration controller.
package hist_eq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_APPLY = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ADDR_CONTRAST = 2'd0,
    ADDR_UPPER    = 2'd1,
    ADDR_LOWER    = 2'd2,
    ADDR_THR_EN   = 2'd3
  } cfg_addr_e;

  localparam int         DEF_DATA_WIDTH     = 8;
  localparam int         DEF_TIMEOUT_CYCLES = 4194304;
  localparam int         DEF_CONTRAST       = 128;
  localparam logic [9:0] DEF_UPPER          = 10'd717;
  localparam logic [9:0] DEF_LOWER          = 10'd205;
  localparam logic       DEF_THR_EN         = 1'b1;
  localparam int         PIPELINE_LENGTH    = 12;

endpackage

// File: rtl/hist_eq_stall_wdt.sv
// Start-of-frame watchdog: counts cycles since the last SOF, saturating at the timeout.
module hist_eq_stall_wdt
  import hist_eq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic i_sys_clk,
  input  logic i_sys_aresetn,
  input  logic sof,
  output logic expire,
  output logic stall
);

  localparam int             CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;

  // Next count: SOF wins over increment, increment stops at the limit.
  always_comb begin
    cnt_s = cnt_r;
    if (sof) begin
      cnt_s = {CW{1'b0}};
    end else if (cnt_r == LIMIT) begin
      cnt_s = LIMIT;
    end else begin
      cnt_s = cnt_r + CW'(32'd1);
    end
  end

  // expire flags the edge at which the count lands on (or stays at) the limit.
  assign expire = (cnt_s == LIMIT);

  // Counter and registered stall flag.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_aresetn) begin
      cnt_r <= {CW{1'b0}};
      stall <= 1'b0;
    end else begin
      cnt_r <= cnt_s;
      stall <= (cnt_s == LIMIT);
    end
  end

endmodule

// File: rtl/hist_eq_cfg_ctrl.sv
// Shadow/active configuration controller: validated commits apply at the next frame start,
// or are forced through when the input stream stalls.
module hist_eq_cfg_ctrl
  import hist_eq_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_aresetn,
  input  logic                  cfg_wr_valid,
  output logic                  cfg_wr_ready,
  input  logic [1:0]            cfg_wr_addr,
  input  logic [9:0]            cfg_wr_data,
  input  logic                  cfg_commit,
  input  logic                  mon_tvalid,
  input  logic                  mon_tuser,
  output logic [DATA_WIDTH-1:0] contrast_threshold_param,
  output logic [9:0]            upper_bound_param,
  output logic [9:0]            lower_bound_param,
  output logic                  thresholding_en,
  output logic                  cfg_pending,
  output logic                  cfg_applied,
  output logic                  cfg_err,
  output logic                  cfg_forced,
  output logic                  stream_stall,
  output logic [15:0]           frame_cnt
);

  localparam logic [DATA_WIDTH-1:0] DEF_CT = DATA_WIDTH'(DEF_CONTRAST);

  state_e                  state_r;
  logic [DATA_WIDTH-1:0]   sh_contrast_r, sh_contrast_s;
  logic [9:0]              sh_upper_r, sh_upper_s;
  logic [9:0]              sh_lower_r, sh_lower_s;
  logic                    sh_thr_en_r, sh_thr_en_s;
  logic                    sof_s;
  logic                    wr_en_s;
  logic                    valid_s;
  logic                    expire_s;

  assign sof_s   = mon_tvalid & mon_tuser;
  assign wr_en_s = cfg_wr_valid & cfg_wr_ready;

  hist_eq_stall_wdt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdt (
    .i_sys_clk    (i_sys_clk),
    .i_sys_aresetn(i_sys_aresetn),
    .sof          (sof_s),
    .expire       (expire_s),
    .stall        (stream_stall)
  );

  // Post-write shadow view, so a same-cycle commit validates the new value.
  always_comb begin
    sh_contrast_s = sh_contrast_r;
    sh_upper_s    = sh_upper_r;
    sh_lower_s    = sh_lower_r;
    sh_thr_en_s   = sh_thr_en_r;
    if (wr_en_s) begin
      case (cfg_addr_e'(cfg_wr_addr))
        ADDR_CONTRAST: sh_contrast_s = cfg_wr_data[DATA_WIDTH-1:0];
        ADDR_UPPER:    sh_upper_s    = cfg_wr_data;
        ADDR_LOWER:    sh_lower_s    = cfg_wr_data;
        ADDR_THR_EN:   sh_thr_en_s   = cfg_wr_data[0];
        default:       sh_thr_en_s   = sh_thr_en_r;
      endcase
    end else begin
      sh_thr_en_s = sh_thr_en_r;
    end
  end

  assign valid_s = (sh_lower_s < sh_upper_s) && (sh_upper_s != 10'd0);

  // Commit FSM with shadow/active registers and registered status outputs.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_aresetn) begin
      state_r                  <= ST_IDLE;
      sh_contrast_r            <= DEF_CT;
      sh_upper_r               <= DEF_UPPER;
      sh_lower_r               <= DEF_LOWER;
      sh_thr_en_r              <= DEF_THR_EN;
      contrast_threshold_param <= DEF_CT;
      upper_bound_param        <= DEF_UPPER;
      lower_bound_param        <= DEF_LOWER;
      thresholding_en          <= DEF_THR_EN;
      cfg_wr_ready             <= 1'b1;
      cfg_pending              <= 1'b0;
      cfg_applied              <= 1'b0;
      cfg_err                  <= 1'b0;
      cfg_forced               <= 1'b0;
      frame_cnt                <= 16'd0;
    end else begin
      sh_contrast_r <= sh_contrast_s;
      sh_upper_r    <= sh_upper_s;
      sh_lower_r    <= sh_lower_s;
      sh_thr_en_r   <= sh_thr_en_s;
      if (sof_s) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (cfg_commit && valid_s) begin
            cfg_err      <= 1'b0;
            cfg_forced   <= 1'b0;
            cfg_pending  <= 1'b1;
            cfg_wr_ready <= 1'b0;
            state_r      <= ST_ARMED;
          end else if (cfg_commit) begin
            cfg_err <= 1'b1;
          end
        end
        ST_ARMED: begin
          // A SOF on the expiry edge is a normal apply, never a forced one.
          if (sof_s || expire_s) begin
            contrast_threshold_param <= sh_contrast_r;
            upper_bound_param        <= sh_upper_r;
            lower_bound_param        <= sh_lower_r;
            thresholding_en          <= sh_thr_en_r;
            cfg_forced               <= cfg_forced | ~sof_s;
            cfg_pending              <= 1'b0;
            cfg_applied              <= 1'b1;
            state_r                  <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          cfg_applied  <= 1'b0;
          cfg_wr_ready <= 1'b1;
          state_r      <= ST_IDLE;
        end
        default: begin
          cfg_pending  <= 1'b0;
          cfg_applied  <= 1'b0;
          cfg_wr_ready <= 1'b1;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
